// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time UART program loader.
package loader_pkg;

  // Parser states of the loader
  typedef enum logic [2:0] {
    LEN,
    DATA,
    ACK,
    RUN,
    ERR,
    HALT
  } state_t;

  // Receiver frame phases
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: synchroniser, bit timer and LSB-first shift register.
// Emits a one-cycle rx_valid (good stop bit) or rx_ferr (stop bit low).
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 40
) (
  input  logic       core_clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          rxd_meta, rxd_sync, rxd_prev;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          valid_n, ferr_n;

  assign rx_byte = shift;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Receiver state, bit timer, shift register and registered strobes
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      rx_valid <= valid_n;
      rx_ferr  <= ferr_n;
    end
  end

  // Frame sequencing: mid-start re-check, then one sample per bit period
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rxd_prev && !rxd_sync) begin
          state_n = RX_START;
        end
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          if (rxd_sync) begin
            state_n = RX_IDLE;
          end else begin
            state_n   = RX_BITS;
            bit_idx_n = '0;
          end
        end
      end
      RX_BITS: begin
        if (cnt == FULL) begin
          cnt_n     = '0;
          shift_n   = {rxd_sync, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          valid_n = rxd_sync;
          ferr_n  = !rxd_sync;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses a length-prefixed little-endian word stream from the
// UART, writes it to instruction memory, then ACKs/NAKs and releases the core.
module uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 40,
  parameter int ADDR_W       = 10
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  logic              rx_valid, rx_ferr;
  logic [7:0]        rx_byte;

  state_t            state, state_n;
  logic [31:0]       word_cnt, word_cnt_n;
  logic [31:0]       remaining, remaining_n;
  logic [31:0]       assem, assem_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              ok, ok_n;
  logic              imem_we_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [31:0]       imem_wdata_n;
  logic              load_err_n;
  logic [31:0]       len_next, word_next;

  assign len_next  = {rx_byte, word_cnt[31:8]};
  assign word_next = {rx_byte, assem[31:8]};

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .core_clk(core_clk),
    .rst_n   (rst_n),
    .rxd     (rxd),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .rx_ferr (rx_ferr)
  );

  // Parser state, counters and registered memory/core-control outputs
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LEN;
      word_cnt   <= '0;
      remaining  <= '0;
      assem      <= '0;
      byte_cnt   <= '0;
      addr       <= '0;
      ok         <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      word_cnt   <= word_cnt_n;
      remaining  <= remaining_n;
      assem      <= assem_n;
      byte_cnt   <= byte_cnt_n;
      addr       <= addr_n;
      ok         <= ok_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      core_rst_n <= (state_n == RUN);
      load_done  <= (state_n == RUN);
      load_err   <= load_err_n;
    end
  end

  // Next-state logic; tx_start is gated directly by tx_busy so a request
  // can never be raised while the transmitter is occupied
  always_comb begin
    state_n      = state;
    word_cnt_n   = word_cnt;
    remaining_n  = remaining;
    assem_n      = assem;
    byte_cnt_n   = byte_cnt;
    addr_n       = addr;
    ok_n         = ok;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    load_err_n   = load_err;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    case (state)
      LEN: begin
        if (rx_ferr) begin
          state_n = ERR;
        end else if (rx_valid) begin
          word_cnt_n = len_next;
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (len_next == 32'd0) begin
              ok_n    = 1'b1;
              state_n = ACK;
            end else if ({1'b0, len_next} > MAX_WORDS) begin
              state_n = ERR;
            end else begin
              remaining_n = len_next;
              state_n     = DATA;
            end
          end
        end
      end
      DATA: begin
        if (rx_ferr) begin
          state_n = ERR;
        end else if (rx_valid) begin
          assem_n    = word_next;
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_we_n    = 1'b1;
            imem_addr_n  = addr;
            imem_wdata_n = word_next;
            addr_n       = addr + ADDR_W'(1);
            remaining_n  = remaining - 32'd1;
            if (remaining == 32'd1) begin
              ok_n    = 1'b1;
              state_n = ACK;
            end
          end
        end
      end
      ACK: begin
        tx_data = ok ? ACK_BYTE : NAK_BYTE;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = ok ? RUN : HALT;
        end
      end
      ERR: begin
        ok_n       = 1'b0;
        load_err_n = 1'b1;
        state_n    = ACK;
      end
      RUN:     state_n = RUN;
      HALT:    state_n = HALT;
      default: state_n = LEN;
    endcase
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised scoreboard bench for uart_loader. Expected writes and ACK/NAK
// bytes come from a stream-level model of the load protocol.
`timescale 1ns/1ps
module tb_uart_loader;

  localparam int CPB       = 40;
  localparam int AW        = 2;
  localparam int MAX_WORDS = 1 << AW;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          core_clk = 1'b0;
  logic          rst_n    = 1'b0;
  logic          rxd      = 1'b1;
  logic          tx_busy  = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  wr_t  exp_wr_q[$];
  logic [7:0] exp_tx_q[$];
  logic exp_done, exp_err;
  logic tx_pending    = 1'b0;
  logic tx_pending_ok = 1'b0;
  int   tx_cyc        = -1;
  int   release_cyc;
  wr_t  mon_wr;
  logic [7:0] mon_tx;

  uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW)
  ) dut (
    .core_clk  (core_clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .core_rst_n(core_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) cyc <= cyc + 1;

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes memory or transmits
  always @(negedge core_clk) begin
    if (rst_n) begin
      if (tx_pending) begin
        checkOutput("core_rst_n after tx_start", 32'(core_rst_n), 32'(tx_pending_ok));
        checkOutput("load_done after tx_start", 32'(load_done), 32'(tx_pending_ok));
        tx_pending = 1'b0;
      end
      if (imem_we) begin
        if (exp_wr_q.size() == 0) begin
          checkOutput("expected write pending", 32'(exp_wr_q.size() != 0), 32'd1);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          checkOutput("imem_addr", 32'(imem_addr), 32'(mon_wr.addr));
          checkOutput("imem_wdata", imem_wdata, mon_wr.data);
        end
      end
      if (tx_start) begin
        tx_cyc = cyc;
        checkOutput("tx_busy low at tx_start", 32'(tx_busy), 32'd0);
        checkOutput("core_rst_n held at tx_start", 32'(core_rst_n), 32'd0);
        if (exp_tx_q.size() == 0) begin
          checkOutput("expected tx pending", 32'(exp_tx_q.size() != 0), 32'd1);
        end else begin
          mon_tx = exp_tx_q.pop_front();
          checkOutput("tx_data", 32'(tx_data), 32'(mon_tx));
          tx_pending    = 1'b1;
          tx_pending_ok = (mon_tx == 8'h06);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " imem_we"},    32'(imem_we),    32'd0);
    checkOutput({tag, " imem_addr"},  32'(imem_addr),  32'd0);
    checkOutput({tag, " imem_wdata"}, imem_wdata,      32'd0);
    checkOutput({tag, " tx_start"},   32'(tx_start),   32'd0);
    checkOutput({tag, " tx_data"},    32'(tx_data),    32'd0);
    checkOutput({tag, " core_rst_n"}, 32'(core_rst_n), 32'd0);
    checkOutput({tag, " load_done"},  32'(load_done),  32'd0);
    checkOutput({tag, " load_err"},   32'(load_err),   32'd0);
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    rxd     = 1'b1;
    tx_busy = 1'b0;
    exp_wr_q.delete();
    exp_tx_q.delete();
    waitCycles(3);
    checkResetValues("reset");
    rst_n = 1'b1;
    waitCycles(3);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stop_ok);
    rxd = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      waitCycles(CPB);
    end
    rxd = stop_ok;
    waitCycles(CPB);
    rxd = 1'b1;
    waitCycles(stop_ok ? CPB : 2 * CPB);
  endtask

  // Stream-level model: decode count, cut the stream at a framing error,
  // and predict the word writes plus the ACK/NAK byte
  task automatic predictLoad(input byte_q_t bytes, input int bad_idx, output logic has_tx);
    int     lim;
    longint count;
    int     words;
    int     n;
    wr_t    w;
    lim      = (bad_idx >= 0) ? bad_idx : bytes.size();
    has_tx   = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (lim < 4) begin
      if (bad_idx >= 0) begin
        exp_tx_q.push_back(8'h15);
        has_tx  = 1'b1;
        exp_err = 1'b1;
      end
    end else begin
      count = longint'(bytes[0]) + longint'(bytes[1]) * 256 +
              longint'(bytes[2]) * 65536 + longint'(bytes[3]) * 16777216;
      if (count == 0) begin
        exp_tx_q.push_back(8'h06);
        has_tx   = 1'b1;
        exp_done = 1'b1;
      end else if (count > MAX_WORDS) begin
        exp_tx_q.push_back(8'h15);
        has_tx  = 1'b1;
        exp_err = 1'b1;
      end else begin
        words = (lim - 4) / 4;
        n     = (words < int'(count)) ? words : int'(count);
        for (int k = 0; k < n; k++) begin
          w.addr = AW'(k);
          w.data = {bytes[4 + 4*k + 3], bytes[4 + 4*k + 2], bytes[4 + 4*k + 1], bytes[4 + 4*k]};
          exp_wr_q.push_back(w);
        end
        if (words >= int'(count)) begin
          exp_tx_q.push_back(8'h06);
          has_tx   = 1'b1;
          exp_done = 1'b1;
        end else if (bad_idx >= 0) begin
          exp_tx_q.push_back(8'h15);
          has_tx  = 1'b1;
          exp_err = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input byte_q_t bytes, input int bad_idx, input int busy_hold);
    logic has_tx;
    predictLoad(bytes, bad_idx, has_tx);
    if (busy_hold > 0) tx_busy = 1'b1;
    foreach (bytes[i]) sendByte(bytes[i], i != bad_idx);
    if (busy_hold > 0) begin
      waitCycles(busy_hold);
      checkOutput("tx deferred while busy", 32'(exp_tx_q.size()), 32'(has_tx));
      tx_busy     = 1'b0;
      release_cyc = cyc;
      waitCycles(2);
      checkOutput("tx_start cycle vs busy release", 32'(tx_cyc), 32'(release_cyc));
    end
    for (int k = 0; k < 3000 && exp_tx_q.size() != 0; k++) waitCycles(1);
    checkOutput("pending tx after load", 32'(exp_tx_q.size()), 32'd0);
    waitCycles(10);
    checkOutput("pending writes after load", 32'(exp_wr_q.size()), 32'd0);
    checkOutput("core_rst_n final", 32'(core_rst_n), 32'(exp_done));
    checkOutput("load_done final", 32'(load_done), 32'(exp_done));
    checkOutput("load_err final", 32'(load_err), 32'(exp_err));
  endtask

  initial begin
    byte_q_t q;
    logic    has_tx;
    int      cnt;
    int      nb;

    $display("[TB] single-word load");
    doReset();
    q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h19, 8'h31, 8'h61};
    applyStimulus(q, -1, 0);

    $display("[TB] three-word load");
    doReset();
    q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
          8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(q, -1, 0);

    $display("[TB] zero count");
    doReset();
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(q, -1, 0);

    $display("[TB] oversize count with trailing bytes");
    doReset();
    q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(q, -1, 0);

    $display("[TB] maximum count");
    doReset();
    q = '{8'h04, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    applyStimulus(q, -1, 0);

    $display("[TB] framing error during DATA");
    doReset();
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(q, 8, 0);

    $display("[TB] start-bit glitch then load");
    doReset();
    rxd = 1'b0;
    waitCycles(5);
    rxd = 1'b1;
    waitCycles(100);
    q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    applyStimulus(q, -1, 0);

    $display("[TB] reset during second data byte");
    doReset();
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA};
    predictLoad(q, -1, has_tx);
    foreach (q[i]) sendByte(q[i], 1'b1);
    rxd = 1'b0;
    waitCycles(CPB);
    rxd = 1'b1;
    waitCycles(3 * CPB);
    rst_n = 1'b0;
    #1;
    checkResetValues("mid-load reset");
    checkOutput("writes before mid-load reset", 32'(exp_wr_q.size()), 32'd0);
    doReset();
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40,
          8'h50, 8'h60, 8'h70, 8'h80};
    applyStimulus(q, -1, 0);

    $display("[TB] transmitter busy during ACK");
    doReset();
    q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h99, 8'h88, 8'h77, 8'h66};
    applyStimulus(q, -1, 100);

    for (int r = 0; r < 2; r++) begin
      $display("[TB] random load %0d", r);
      doReset();
      cnt = $urandom_range(0, 6);
      q.delete();
      q.push_back(8'(cnt));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
      nb = (cnt <= MAX_WORDS) ? 4 * cnt : 4;
      for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
      applyStimulus(q, -1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 40)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader between the serial `rxd` pin and the core's instruction memory. Deserialises 8N1 UART bytes, parses a length-prefixed little-endian word stream and writes each word to instruction memory. Holds the core in reset until the load completes, then sends a one-byte ACK or NAK through the existing UART transmitter and releases the core.

## Interface
- `CLKS_PER_BIT`, default 40: `core_clk` cycles per UART bit.
- `ADDR_W`, default 10: instruction-memory word-address width.
- `core_clk` input, 1: the single clock; all logic is rising-edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `rxd` input, 1: UART receive line; idles high.
- `imem_we` output, 1: one-cycle write strobe.
- `imem_addr` output, ADDR_W: word address.
- `imem_wdata` output, 32: word to write.
- `tx_data` output, 8: byte for the transmitter.
- `tx_start` output, 1: one-cycle transmit request.
- `tx_busy` input, 1: transmitter is busy.
- `core_rst_n` output, 1: active-low reset to the core.
- `load_done` output, 1: program loaded successfully.
- `load_err` output, 1: sticky error flag.

## Operation
- Sub-module `uart_rx_core`:
  - Two-flop synchroniser on `rxd`.
  - A falling edge starts a frame. The start bit is re-checked at count CLKS_PER_BIT/2; if it is high, the frame is a glitch and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT cycles from mid-start, LSB first.
  - The stop bit is sampled at mid-bit. The sub-module then pulses `rx_valid` for one cycle with `rx_byte`, and sets `rx_ferr` instead if the stop bit is 0.
- Loader FSM:
  - **LEN**: collect 4 bytes, little-endian, into `word_cnt[31:0]`. After the 4th byte:
    - `word_cnt` == 0 -> ACK with `ok`.
    - `word_cnt` > 2^ADDR_W -> ERR.
    - otherwise -> DATA.
  - **DATA**: shift bytes into a 32-bit little-endian assembler; the first byte received becomes bits [7:0].
    - On the 4th byte of a word: pulse `imem_we`, increment `addr`, decrement `remaining`.
    - When `remaining` reaches 0 -> ACK with `ok`.
  - **ACK**: wait for `tx_busy`=0, then pulse `tx_start` for one cycle.
    - `tx_data` = 0x06 if `ok`, 0x15 if not.
    - Next state is RUN if `ok`, HALT if not.
  - **RUN**: `core_rst_n`=1, `load_done`=1. All further rx bytes are ignored.
  - **ERR**: set `load_err`, clear `ok`, go to ACK.
  - **HALT**: terminal state. `core_rst_n` stays 0 and `load_err` stays 1 until `rst_n`.
- `rx_ferr` in LEN or DATA -> ERR. In any other state it is ignored.
- Byte counter (2 bits) wraps 3->0 at each word boundary.
- `addr` never exceeds `word_cnt`-1, so no wrap is possible.

## Timing
- Reset values:
  - Outputs: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `tx_start`=0, `tx_data`=0, `core_rst_n`=0, `load_done`=0, `load_err`=0.
  - FSM in LEN; all counters 0.
- `rx_valid` fires 1 cycle after the mid-stop-bit sample.
- `imem_we` is registered and asserts 1 cycle after the `rx_valid` of the 4th byte. `imem_addr` and `imem_wdata` are stable in that same cycle.
- The ACK decision is made in the cycle after the final `rx_valid`. `tx_start` asserts on the first cycle with `tx_busy`=0, at the earliest 1 cycle after entering ACK.
- `core_rst_n` rises the cycle after `tx_start`. `tx_start` is never asserted while `tx_busy`=1.
- Reset mid-frame or mid-load: everything aborts immediately. Memory contents written so far are left as-is; reload starts from LEN.
- If `rx_valid` and the final decrement coincide, the word write still happens; ACK follows the write.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum (LEN, DATA, ACK, RUN, ERR, HALT);
  - constants `ACK_BYTE`=0x06 and `NAK_BYTE`=0x15.
- One sub-module, `uart_rx_core`, containing the synchroniser, bit timer and shift register. The parser FSM stays in `uart_loader`.
- Expected size: about 250 RTL lines total.

## Test plan
- **Single-word load.** Drive bytes 01 00 00 00 then 0D 19 31 61 at 40 clks/bit.
  - One `imem_we`: addr 0, data 0x6131190D.
  - `tx_start` with 0x06.
  - `core_rst_n` rises; `load_done`=1.
- **Three-word load.** Drive count 03 00 00 00 and 12 data bytes.
  - Three writes at addr 0, 1, 2 with the correct little-endian words.
  - No fourth write; then ACK.
- **Zero count.** Drive 00 00 00 00.
  - No `imem_we`.
  - Immediate ACK 0x06 and RUN.
- **Oversize count.** With ADDR_W=2, drive count 05 00 00 00.
  - ERR, then NAK 0x15.
  - `load_err`=1 and `core_rst_n` stays 0.
  - Following bytes produce no writes.
- **Framing error and glitch.**
  - A stop bit of 0 during DATA -> NAK and HALT.
  - Separately, a 5-cycle low glitch on `rxd` -> no `rx_valid`.
- **Reset and transmitter handshake.**
  - Assert `rst_n`=0 mid-way through the 2nd data byte: all outputs return to their reset values. A clean reload then succeeds from addr 0.
  - Hold `tx_busy`=1 for 100 cycles during ACK: `tx_start` waits and fires on the first cycle with `tx_busy`=0.
